// File: rtl/spi_slave_verb.sv
// spi_slave_verb: single-lane full-duplex SPI target.
//
// SCK, CSN and MOSI are oversampled on the local clock. MOSI bits are packed
// MSB first into CSNUM-bit words on a valid/ready read port. MISO is shifted
// out of a TX shift register that is reloaded from a one-entry holding
// register. If the holding register is empty at reload time, the FILL word
// is sent instead.
//
// Parameters:
//   PHASE       CPHA. 0: sample on leading edge, 1: sample on trailing edge
//   ACTIVE      CPOL (idle level of SCK)
//   CSNUM       bits per word (4..32)
//   SYNC_STAGES synchroniser depth (2..3)
//   FILL        word sent on underrun, truncated to CSNUM bits
//
// Ports:
//   clock, rst_n               system clock (>= 4x SCK), async active-low reset
//   spi_csn/sck/mosi           SPI bus inputs
//   spi_miso, spi_miso_oe      SPI data out and its output enable
//   wr_vld/wr_data/wr_ready    TX holding register write port
//   rd_vld/rd_data/rd_ready    RX word read port (rd_vld held until accepted)
//   busy                       frame in progress
//   frame_end, overrun,
//   underrun, frame_err        one-cycle status pulses
//   word_cnt                   words received in the current/last frame
//
// Build option: define SPI_SLAVE_WORD_CNT_EN to build the word counter;
// without it word_cnt is tied to zero.
module spi_slave_verb #(
    parameter bit          PHASE       = 1'b0,
    parameter bit          ACTIVE      = 1'b0,
    parameter int          CSNUM       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] FILL        = 32'h0000_00FF
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             spi_csn,
    input  logic             spi_sck,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    input  logic             wr_vld,
    input  logic [CSNUM-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_vld,
    output logic [CSNUM-1:0] rd_data,
    input  logic             rd_ready,
    output logic             busy,
    output logic             frame_end,
    output logic             overrun,
    output logic             underrun,
    output logic             frame_err,
    output logic [15:0]      word_cnt
);

    localparam int               BCW    = $clog2(CSNUM);
    localparam logic [BCW-1:0]   LAST   = BCW'(CSNUM - 1);
    localparam logic [CSNUM-1:0] FILL_W = FILL[CSNUM-1:0];

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
    logic                   sck_prev, csn_prev;
    logic                   sck_p0, csn_p0;
    logic                   lead_e, trail_e;
    logic                   sample_p1, shift_p1, fall_p1, rise_p1, mosi_p1;
    logic [CSNUM-1:0]       tx_shift;
    logic [CSNUM-2:0]       rx_shift;
    logic [CSNUM-1:0]       rx_next;
    logic [BCW-1:0]         bit_cnt;
    logic                   reload_pend;
    logic [CSNUM-1:0]       hold_data;
    logic [CSNUM-1:0]       reload_word;
    logic                   reload_fill;
    logic                   do_reload;
    logic                   wr_fire;

    // ---- stage p0: synchronisers and previous-value flops ----
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= {SYNC_STAGES{ACTIVE}};
            csn_sync  <= '1;
            mosi_sync <= '0;
            sck_prev  <= ACTIVE;
            csn_prev  <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_prev  <= sck_sync[SYNC_STAGES-1];
            csn_prev  <= csn_sync[SYNC_STAGES-1];
        end
    end

    assign sck_p0  = sck_sync[SYNC_STAGES-1];
    assign csn_p0  = csn_sync[SYNC_STAGES-1];
    assign lead_e  = (sck_prev == ACTIVE) && (sck_p0 != ACTIVE);
    assign trail_e = (sck_prev != ACTIVE) && (sck_p0 == ACTIVE);

    // ---- stage p1: registered edge pulses, MOSI kept aligned with them ----
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sample_p1 <= 1'b0;
            shift_p1  <= 1'b0;
            fall_p1   <= 1'b0;
            rise_p1   <= 1'b0;
            mosi_p1   <= 1'b0;
        end else begin
            sample_p1 <= PHASE ? trail_e : lead_e;
            shift_p1  <= PHASE ? lead_e : trail_e;
            fall_p1   <= csn_prev && !csn_p0;
            rise_p1   <= !csn_prev && csn_p0;
            mosi_p1   <= mosi_sync[SYNC_STAGES-1];
        end
    end

    // Word source for a TX reload: a full holding register first, then a word
    // being written this very cycle (bypass), otherwise FILL.
    always_comb begin
        reload_word = FILL_W;
        reload_fill = 1'b1;
        if (!wr_ready) begin
            reload_word = hold_data;
            reload_fill = 1'b0;
        end else if (wr_vld) begin
            reload_word = wr_data;
            reload_fill = 1'b0;
        end
    end

    assign wr_fire   = wr_vld && wr_ready;
    assign do_reload = !rise_p1 &&
                       ((state == LOAD) || ((state == SHIFT) && shift_p1 && reload_pend));
    assign rx_next   = {rx_shift, mosi_p1};

    assign spi_miso_oe = busy;

    // ---- stage p2: frame FSM, shift registers and port registers ----
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            hold_data   <= '0;
            wr_ready    <= 1'b1;
            spi_miso    <= 1'b0;
            rd_vld      <= 1'b0;
            rd_data     <= '0;
            frame_end   <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;

            if (do_reload) begin
                underrun <= reload_fill;
                wr_ready <= 1'b1;
            end else if (wr_fire) begin
                hold_data <= wr_data;
                wr_ready  <= 1'b0;
            end

            // A word completing in this same cycle overrides the clear below.
            if (rd_vld && rd_ready) rd_vld <= 1'b0;

            if (rise_p1) begin
                state     <= IDLE;
                busy      <= 1'b0;
                frame_end <= 1'b1;
                frame_err <= (state == SHIFT) && (bit_cnt != '0);
            end else begin
                case (state)
                    IDLE: begin
                        if (fall_p1) begin
                            state <= LOAD;
                            busy  <= 1'b1;
                        end
                    end
                    LOAD: begin
                        tx_shift    <= reload_word;
                        spi_miso    <= reload_word[CSNUM-1];
                        bit_cnt     <= '0;
                        reload_pend <= 1'b0;
                        state       <= SHIFT;
                    end
                    SHIFT: begin
                        if (sample_p1) begin
                            rx_shift <= rx_next[CSNUM-2:0];
                            if (bit_cnt == LAST) begin
                                bit_cnt     <= '0;
                                rd_data     <= rx_next;
                                rd_vld      <= 1'b1;
                                overrun     <= rd_vld && !rd_ready;
                                reload_pend <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + BCW'(1);
                            end
                        end else if (shift_p1) begin
                            // tx_shift[MSB] is the bit on the wire for PHASE=0,
                            // and the next bit to drive for PHASE=1.
                            if (reload_pend) begin
                                reload_pend <= 1'b0;
                                spi_miso    <= reload_word[CSNUM-1];
                                tx_shift    <= PHASE ? (reload_word << 1) : reload_word;
                            end else if (PHASE) begin
                                spi_miso <= tx_shift[CSNUM-1];
                                tx_shift <= tx_shift << 1;
                            end else begin
                                spi_miso <= tx_shift[CSNUM-2];
                                tx_shift <= tx_shift << 1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_WORD_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic word_done;
    assign word_done = !rise_p1 && (state == SHIFT) && sample_p1 && (bit_cnt == LAST);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (!rise_p1 && (state == IDLE) && fall_p1) begin
            word_cnt <= '0;
        end else if (word_done) begin
            word_cnt <= sat_inc16(word_cnt);
        end
    end
`else
    assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_slave_verb.sv
`timescale 1ns/1ps
module tb_spi_slave_verb;

`ifdef SPI_SLAVE_WORD_CNT_EN
    localparam int WC_EN = 1;
`else
    localparam int WC_EN = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic csn  [2];
    logic sck  [2];
    logic mosi [2];

    logic        miso0, oe0, wr_vld0, wr_ready0, rd_vld0, rd_ready0;
    logic        busy0, fe0, ov0, un0, ferr0;
    logic [7:0]  wr_data0, rd_data0;
    logic [15:0] wc0;

    logic        miso1, oe1, wr_vld1, wr_ready1, rd_vld1, rd_ready1;
    logic        busy1, fe1, ov1, un1, ferr1;
    logic [15:0] wr_data1, rd_data1;
    logic [15:0] wc1;

    spi_slave_verb #(.PHASE(1'b0), .ACTIVE(1'b0), .CSNUM(8)) dut0 (
        .clock(clk), .rst_n(rst_n),
        .spi_csn(csn[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso0), .spi_miso_oe(oe0),
        .wr_vld(wr_vld0), .wr_data(wr_data0), .wr_ready(wr_ready0),
        .rd_vld(rd_vld0), .rd_data(rd_data0), .rd_ready(rd_ready0),
        .busy(busy0), .frame_end(fe0), .overrun(ov0), .underrun(un0),
        .frame_err(ferr0), .word_cnt(wc0)
    );

    spi_slave_verb #(.PHASE(1'b1), .ACTIVE(1'b1), .CSNUM(16)) dut1 (
        .clock(clk), .rst_n(rst_n),
        .spi_csn(csn[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso1), .spi_miso_oe(oe1),
        .wr_vld(wr_vld1), .wr_data(wr_data1), .wr_ready(wr_ready1),
        .rd_vld(rd_vld1), .rd_data(rd_data1), .rd_ready(rd_ready1),
        .busy(busy1), .frame_end(fe1), .overrun(ov1), .underrun(un1),
        .frame_err(ferr1), .word_cnt(wc1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse and word monitor for dut0, sampled on the falling clock edge.
    int         n_fe0 = 0, n_ferr0 = 0, n_ov0 = 0, n_un0 = 0, n_vld0 = 0;
    logic [7:0] words0 [$];
    logic       vld_q0 = 1'b0;
    logic [7:0] data_q0 = '0;
    always @(negedge clk) begin
        if (fe0)   n_fe0++;
        if (ferr0) n_ferr0++;
        if (ov0)   n_ov0++;
        if (un0)   n_un0++;
        if (rd_vld0 && !vld_q0) n_vld0++;
        if (rd_vld0 && (!vld_q0 || rd_data0 != data_q0)) words0.push_back(rd_data0);
        vld_q0  = rd_vld0;
        data_q0 = rd_data0;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic miso_of(input int sel);
        return (sel == 0) ? miso0 : miso1;
    endfunction

    task automatic csn_low(input int sel);
        csn[sel] = 1'b0;
        tick(8);
    endtask

    task automatic csn_high(input int sel);
        tick(4);
        csn[sel] = 1'b1;
        tick(10);
    endtask

    // SPI master, 8 clocks per SCK period. sel 0: CPOL0/CPHA0, sel 1: CPOL1/CPHA1.
    task automatic xfer_word(input int sel, input int nbits, input logic [31:0] tx,
                             output logic [31:0] rx);
        logic cpol, cpha;
        cpol = (sel == 1);
        cpha = (sel == 1);
        rx = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) mosi[sel] = tx[i];
            tick(4);
            sck[sel] = ~cpol;
            if (cpha) mosi[sel] = tx[i];
            else      rx = {rx[30:0], miso_of(sel)};
            tick(4);
            if (cpha) rx = {rx[30:0], miso_of(sel)};
            sck[sel] = cpol;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rx, rxa, rxb;
        int b_fe, b_ferr, b_ov, b_un, b_vld, b_w, un_snap;

        rst_n = 1'b0;
        csn[0] = 1'b1; sck[0] = 1'b0; mosi[0] = 1'b0;
        csn[1] = 1'b1; sck[1] = 1'b1; mosi[1] = 1'b0;
        wr_vld0 = 1'b0; wr_data0 = '0; rd_ready0 = 1'b0;
        wr_vld1 = 1'b0; wr_data1 = '0; rd_ready1 = 1'b0;
        tick(3);

        // Reset state
        check_eq("rst_wr_ready", wr_ready0, 1);
        check_eq("rst_rd_vld",   rd_vld0, 0);
        check_eq("rst_miso",     miso0, 0);
        check_eq("rst_miso_oe",  oe0, 0);
        check_eq("rst_busy",     busy0, 0);
        check_eq("rst_word_cnt", wc0, 0);
        check_eq("rst_rd_data",  rd_data0, 0);
        check_eq("rst_wr_ready1", wr_ready1, 1);
        rst_n = 1'b1;
        tick(5);
        check_eq("idle_no_frame_end", n_fe0, 0);

        // Single word: preload A5, master sends 3C
        rd_ready0 = 1'b1;
        wr_data0 = 8'hA5; wr_vld0 = 1'b1;
        tick(1);
        wr_vld0 = 1'b0;
        check_eq("t1_hold_full", wr_ready0, 0);
        b_fe = n_fe0; b_ferr = n_ferr0; b_ov = n_ov0; b_un = n_un0; b_vld = n_vld0; b_w = words0.size();
        csn_low(0);
        check_eq("t1_busy", busy0, 1);
        check_eq("t1_miso_oe", oe0, 1);
        check_eq("t1_hold_consumed", wr_ready0, 1);
        xfer_word(0, 8, 32'h3C, rx);
        un_snap = n_un0 - b_un;
        csn_high(0);
        check_eq("t1_master_rx", rx, 32'hA5);
        check_eq("t1_rd_vld_count", n_vld0 - b_vld, 1);
        check_eq("t1_word_count", words0.size() - b_w, 1);
        check_eq("t1_rd_data", words0[words0.size()-1], 8'h3C);
        check_eq("t1_frame_end", n_fe0 - b_fe, 1);
        check_eq("t1_frame_err", n_ferr0 - b_ferr, 0);
        check_eq("t1_overrun", n_ov0 - b_ov, 0);
        check_eq("t1_underrun", un_snap, 0);
        check_eq("t1_word_cnt", wc0, 1 * WC_EN);
        check_eq("t1_oe_after", oe0, 0);

        // Two words, nothing preloaded. The underrun count is taken before the
        // trailing edge after the last bit prefetches for a would-be third word.
        b_un = n_un0; b_w = words0.size();
        csn_low(0);
        xfer_word(0, 8, 32'h12, rxa);
        xfer_word(0, 8, 32'h34, rxb);
        un_snap = n_un0 - b_un;
        csn_high(0);
        check_eq("t2_master_rx0", rxa, 32'hFF);
        check_eq("t2_master_rx1", rxb, 32'hFF);
        check_eq("t2_underrun", un_snap, 2);
        check_eq("t2_word_count", words0.size() - b_w, 2);
        check_eq("t2_rd_data0", words0[b_w], 8'h12);
        check_eq("t2_rd_data1", words0[b_w+1], 8'h34);
        check_eq("t2_word_cnt", wc0, 2 * WC_EN);

        // Three words with rd_ready held low
        rd_ready0 = 1'b0;
        b_ov = n_ov0; b_vld = n_vld0;
        csn_low(0);
        xfer_word(0, 8, 32'h01, rx);
        xfer_word(0, 8, 32'h02, rx);
        xfer_word(0, 8, 32'h03, rx);
        csn_high(0);
        check_eq("t3_overrun", n_ov0 - b_ov, 2);
        check_eq("t3_rd_data", rd_data0, 8'h03);
        check_eq("t3_rd_vld", rd_vld0, 1);
        check_eq("t3_rd_vld_rises", n_vld0 - b_vld, 1);
        tick(3);
        check_eq("t3_rd_vld_held", rd_vld0, 1);
        rd_ready0 = 1'b1;
        tick(1);
        check_eq("t3_rd_vld_cleared", rd_vld0, 0);

        // CSN raised after 5 bits
        b_fe = n_fe0; b_ferr = n_ferr0; b_vld = n_vld0;
        csn_low(0);
        xfer_word(0, 5, 32'h15, rx);
        check_eq("t4_oe_mid", oe0, 1);
        csn_high(0);
        check_eq("t4_frame_err", n_ferr0 - b_ferr, 1);
        check_eq("t4_frame_end", n_fe0 - b_fe, 1);
        check_eq("t4_no_rd_vld", n_vld0 - b_vld, 0);
        check_eq("t4_oe_after", oe0, 0);
        check_eq("t4_busy_after", busy0, 0);

        // CPHA=1, CPOL=1, 16-bit words
        wr_data1 = 16'h1234; wr_vld1 = 1'b1;
        tick(1);
        wr_vld1 = 1'b0;
        csn_low(1);
        xfer_word(1, 16, 32'hBEEF, rx);
        csn_high(1);
        check_eq("t5_master_rx", rx, 32'h1234);
        check_eq("t5_rd_data", rd_data1, 16'hBEEF);
        check_eq("t5_rd_vld", rd_vld1, 1);

        // Reset mid-word, then a clean frame
        csn_low(0);
        xfer_word(0, 3, 32'h5, rx);
        rst_n = 1'b0;
        tick(1);
        check_eq("t6_wr_ready", wr_ready0, 1);
        check_eq("t6_miso", miso0, 0);
        check_eq("t6_miso_oe", oe0, 0);
        check_eq("t6_busy", busy0, 0);
        check_eq("t6_word_cnt", wc0, 0);
        check_eq("t6_rd_vld1", rd_vld1, 0);
        csn[0] = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        b_ferr = n_ferr0; b_vld = n_vld0; b_w = words0.size();
        csn_low(0);
        xfer_word(0, 8, 32'h5A, rx);
        csn_high(0);
        check_eq("t6_rd_vld_count", n_vld0 - b_vld, 1);
        check_eq("t6_word_count", words0.size() - b_w, 1);
        check_eq("t6_rd_data", words0[words0.size()-1], 8'h5A);
        check_eq("t6_frame_err", n_ferr0 - b_ferr, 0);
        check_eq("t6_new_word_cnt", wc0, 1 * WC_EN);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_verb.md
Name: spi_slave_verb

Overview:
- Single-lane, full-duplex SPI target (slave) block. It is the far-end counterpart of the team's SPI master on the same 4-wire bus.
- Oversamples spi_sck, spi_csn and spi_mosi with the local clock.
- Deserialises MOSI into CSNUM-bit words on a valid/ready read port.
- Serialises words taken from a one-entry write buffer onto MISO.
- Used for loopback benches and for FPGA-as-flash-emulator targets.

Parameters:
- PHASE, 0, CPHA. 0: sample on the leading SCK edge, shift on the trailing edge. 1: shift on leading, sample on trailing.
- ACTIVE, 0, CPOL: idle level of SCK.
- CSNUM, 8, bits per word. Legal range 4..32. Transfers are MSB first.
- SYNC_STAGES, 2, synchroniser depth for SCK/CSN/MOSI. Legal range 2..3.
- FILL, 8'hFF, MISO word sent on underrun. Truncated or zero-extended to CSNUM bits.

Ports:
- clock  input  1  system clock; must be at least 4x the SCK frequency.
- rst_n  input  1  asynchronous active-low reset.
- spi_csn  input  1  chip select, active low.
- spi_sck  input  1  SPI clock.
- spi_mosi  input  1  master-out data.
- spi_miso  output  1  slave-out data.
- spi_miso_oe  output  1  MISO output enable (1 = drive).
- wr_vld  input  1  TX word valid.
- wr_data  input  CSNUM  TX word.
- wr_ready  output  1  TX holding register empty.
- rd_vld  output  1  RX word valid; held until accepted.
- rd_data  output  CSNUM  RX word.
- rd_ready  input  1  RX word accepted.
- busy  output  1  frame in progress (CSN low after synchronisation).
- frame_end  output  1  one-cycle pulse on CSN rise.
- overrun  output  1  one-cycle pulse when an RX word is lost.
- underrun  output  1  one-cycle pulse when FILL is sent.
- frame_err  output  1  one-cycle pulse when CSN rises mid-word.
- word_cnt  output  16  words received in the current/last frame (see Optional Feature).

Behaviour:
- Reset values:
  - All outputs 0 except wr_ready=1 and spi_miso=0.
  - FSM in IDLE; shift registers and bit counter cleared.
- Synchronisation and edge detection:
  - SCK, CSN and MOSI each pass through SYNC_STAGES flops; one extra flop stores the previous SCK/CSN value for edge detection.
  - Leading edge = SCK leaving ACTIVE; trailing edge = SCK returning to ACTIVE.
  - sample_edge = leading if PHASE=0, else trailing. shift_edge = the other edge.
- FSM:
  - IDLE -> LOAD on a synchronised CSN fall.
  - LOAD (1 cycle): loads TX shift register from the holding register if it is full, else from FILL and pulses underrun. Sets holding register empty. Clears bit_cnt. Goes to SHIFT.
  - SHIFT:
    - On sample_edge: rx_shift <= {rx_shift[CSNUM-2:0], mosi_sync}; bit_cnt++.
    - When bit_cnt reaches CSNUM: word completes and bit_cnt wraps to 0.
    - On shift_edge: TX shift register shifts left and spi_miso = its MSB.
    - PHASE=0: the first shift_edge after a word boundary reloads TX (same rule as LOAD) instead of shifting.
    - PHASE=1: the reload happens on the first shift_edge of each word, before the shift.
  - Any state -> IDLE on a synchronised CSN rise:
    - frame_end pulses.
    - If bit_cnt != 0, the partial word is discarded and frame_err pulses.
    - spi_miso_oe drops the same cycle.
- MISO timing:
  - spi_miso_oe = busy.
  - spi_miso updates 1 clock after shift_edge detection. Total delay from the raw SCK edge is SYNC_STAGES+2 clocks.
  - PHASE=0: the first bit is valid 1 cycle after LOAD.
- RX word completion:
  - rd_data <= completed word and rd_vld=1, SYNC_STAGES+2 clocks after the raw sample edge of the last bit.
  - If rd_vld is already 1 and rd_ready=0 at completion: the new word overwrites rd_data, rd_vld stays 1, and overrun pulses.
  - rd_vld&&rd_ready clears rd_vld, unless a new word completes in the same cycle, in which case rd_vld stays 1 with the new data and there is no overrun.
- TX holding register:
  - wr_vld&&wr_ready captures wr_data and drops wr_ready.
  - A same-cycle capture and reload hands the incoming word directly to the shift register, and wr_ready stays 1.
- Edge and reset rules:
  - SCK edges while IDLE are ignored.
  - A CSN fall and SCK edge detected in the same cycle: the CSN fall wins and the edge is ignored.
  - Reset mid-frame returns immediately to reset values; the bus state is not remembered.

Optional Feature:
- Macro SPI_SLAVE_WORD_CNT_EN.
- Defined: word_cnt clears on LOAD from IDLE and increments on each completed RX word, saturating at 16'hFFFF. It holds its value after frame_end until the next frame.
- Undefined: word_cnt is tied to 0 and no counter logic is built.

Test Plan:
- PHASE=0, ACTIVE=0, clock = 8x SCK. Preload wr_data=8'hA5; master sends 8'h3C. -> rd_data=8'h3C with a single rd_vld; master receives 8'hA5; frame_end pulse; no errors.
- Two-word frame with no wr data preloaded; MOSI 8'h12, 8'h34. -> MISO 8'hFF, 8'hFF; two underrun pulses; rd_data 8'h12 then 8'h34; word_cnt=2 with the macro, 0 without.
- rd_ready held 0 across a three-word frame 8'h01, 8'h02, 8'h03. -> two overrun pulses; rd_data=8'h03; rd_vld stays 1 until rd_ready.
- CSN raised after 5 SCK cycles of a word. -> frame_err pulse; no rd_vld; FSM returns to IDLE; spi_miso_oe=0.
- PHASE=1, ACTIVE=1, CSNUM=16, master sends 16'hBEEF with wr_data=16'h1234 preloaded. -> rd_data=16'hBEEF; master receives 16'h1234.
- Assert rst_n low mid-word, then release and run a new frame. -> outputs return to reset values; the new frame 8'h5A is received cleanly.
